// File: rtl/memory_receive_align.sv
// memory_receive_align: load-return stage. Keeps an in-order FIFO of
// metadata for issued loads and, when the data memory returns a word,
// pops the oldest entry and registers the extracted, extended result.
module memory_receive_align #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int REG_SEL_BITS = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [2:0]                load_type,
  input  logic [1:0]                byte_offset,
  input  logic [REG_SEL_BITS-1:0]   load_rd,
  output logic                      issue_ready,
  input  logic                      memory_valid,
  input  logic [DATA_WIDTH-1:0]     memory_read_data,
  input  logic                      flush,
  output logic                      load_valid,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic [REG_SEL_BITS-1:0]   load_rd_out,
  output logic                      load_misaligned,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      unexpected_response
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Byte/half extraction is hard-wired to a 32-bit word and the pointers
  // rely on natural wrap, so reject any other configuration at elaboration.
  if (DATA_WIDTH != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CORE < 0) begin : g_param_check
    $error("memory_receive_align: unsupported parameterisation");
  end

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_e;

  logic [2:0]              type_mem [DEPTH];
  logic [1:0]              off_mem  [DEPTH];
  logic [REG_SEL_BITS-1:0] rd_mem   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic push;
  logic pop;

  logic [2:0]              head_type;
  logic [1:0]              head_off;
  logic [REG_SEL_BITS-1:0] head_rd;

  logic [DATA_WIDTH-1:0] shifted_word;
  logic [15:0]           half_word;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_misaligned;

  // Full is judged on the registered count alone, so a pop in the same
  // cycle never opens a slot for a load presented while full.
  assign issue_ready = (count != FULL_COUNT);

  // A flush discards anything else happening on this edge.
  assign push = load && issue_ready && !flush;
  assign pop  = memory_valid && (count != '0) && !flush;

  assign head_type = type_mem[head];
  assign head_off  = off_mem[head];
  assign head_rd   = rd_mem[head];

  // Metadata storage written at the tail on each accepted load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        type_mem[i] <= '0;
        off_mem[i]  <= '0;
        rd_mem[i]   <= '0;
      end
    end else if (push) begin
      type_mem[tail] <= load_type;
      off_mem[tail]  <= byte_offset;
      rd_mem[tail]   <= load_rd;
    end
  end

  // Head/tail pointers and occupancy; flush returns everything to empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Select, extend and flag the returned word according to the head entry.
  always_comb begin
    shifted_word   = memory_read_data >> {head_off, 3'b000};
    half_word      = head_off[1] ? memory_read_data[31:16] : memory_read_data[15:0];
    ext_data       = memory_read_data;
    ext_misaligned = 1'b0;
    case (head_type)
      LT_LB: begin
        ext_data = {{(DATA_WIDTH-8){shifted_word[7]}}, shifted_word[7:0]};
      end
      LT_LBU: begin
        ext_data = {{(DATA_WIDTH-8){1'b0}}, shifted_word[7:0]};
      end
      LT_LH: begin
        ext_data       = {{(DATA_WIDTH-16){half_word[15]}}, half_word};
        ext_misaligned = head_off[0];
      end
      LT_LHU: begin
        ext_data       = {{(DATA_WIDTH-16){1'b0}}, half_word};
        ext_misaligned = head_off[0];
      end
      LT_LW: begin
        ext_misaligned = (head_off != 2'b00);
      end
      default: begin
        ext_misaligned = 1'b1;
      end
    endcase
  end

  // Result registers: valid pulses per pop, payload holds between pops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_valid      <= 1'b0;
      load_data       <= '0;
      load_rd_out     <= '0;
      load_misaligned <= 1'b0;
    end else begin
      load_valid <= pop;
      if (pop) begin
        load_data       <= ext_data;
        load_rd_out     <= head_rd;
        load_misaligned <= ext_misaligned;
      end
    end
  end

  // Sticky report of a response that had no outstanding load to match.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      unexpected_response <= 1'b0;
    end else if (memory_valid && (count == '0)) begin
      unexpected_response <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_receive_align.sv
// tb_memory_receive_align: table-driven extraction vectors plus hand-written
// sequences for ordering, full back-pressure, flush, unexpected and reset.
module tb_memory_receive_align;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  load_type = 3'b000;
  logic [1:0]  byte_offset = 2'b00;
  logic [4:0]  load_rd = 5'd0;
  logic        issue_ready;
  logic        memory_valid = 1'b0;
  logic [31:0] memory_read_data = 32'h0;
  logic        flush = 1'b0;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd_out;
  logic        load_misaligned;
  logic [2:0]  count;
  logic        unexpected_response;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  ltype;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [15];

  memory_receive_align #(
    .CORE(0), .DATA_WIDTH(32), .DEPTH(4), .REG_SEL_BITS(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .load_type(load_type),
    .byte_offset(byte_offset),
    .load_rd(load_rd),
    .issue_ready(issue_ready),
    .memory_valid(memory_valid),
    .memory_read_data(memory_read_data),
    .flush(flush),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_rd_out(load_rd_out),
    .load_misaligned(load_misaligned),
    .count(count),
    .unexpected_response(unexpected_response)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one load for a single edge.
  task automatic apply_stimulus(input logic [2:0] t, input logic [1:0] off, input logic [4:0] rd);
    load        = 1'b1;
    load_type   = t;
    byte_offset = off;
    load_rd     = rd;
    tick();
    load = 1'b0;
  endtask

  // Present one memory response for a single edge; result is then visible.
  task automatic respond(input logic [31:0] word);
    memory_valid     = 1'b1;
    memory_read_data = word;
    tick();
    memory_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] d, input logic [4:0] rd, input logic mis);
    check_output({tag, " valid"}, 32'(load_valid), 32'd1);
    check_output({tag, " data"}, load_data, d);
    check_output({tag, " rd"}, 32'(load_rd_out), 32'(rd));
    check_output({tag, " misaligned"}, 32'(load_misaligned), 32'(mis));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " issue_ready"}, 32'(issue_ready), 32'd1);
    check_output({tag, " load_valid"}, 32'(load_valid), 32'd0);
    check_output({tag, " load_data"}, load_data, 32'd0);
    check_output({tag, " load_rd_out"}, 32'(load_rd_out), 32'd0);
    check_output({tag, " load_misaligned"}, 32'(load_misaligned), 32'd0);
    check_output({tag, " count"}, 32'(count), 32'd0);
    check_output({tag, " unexpected"}, 32'(unexpected_response), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080, 1'b0};
    vecs[2]  = '{3'b000, 2'd1, 32'h80FF_1234, 32'h0000_0012, 1'b0};
    vecs[3]  = '{3'b000, 2'd2, 32'h80FF_1234, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b100, 2'd0, 32'h80FF_1234, 32'h0000_0034, 1'b0};
    vecs[5]  = '{3'b001, 2'd0, 32'hBEEF_8001, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{3'b101, 2'd2, 32'hBEEF_8001, 32'h0000_BEEF, 1'b0};
    vecs[7]  = '{3'b001, 2'd2, 32'hBEEF_8001, 32'hFFFF_BEEF, 1'b0};
    vecs[8]  = '{3'b010, 2'd0, 32'hBEEF_8001, 32'hBEEF_8001, 1'b0};
    vecs[9]  = '{3'b010, 2'd1, 32'hBEEF_8001, 32'hBEEF_8001, 1'b1};
    vecs[10] = '{3'b001, 2'd3, 32'h1234_5678, 32'h0000_1234, 1'b1};
    vecs[11] = '{3'b101, 2'd1, 32'h1234_5678, 32'h0000_5678, 1'b1};
    vecs[12] = '{3'b011, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[13] = '{3'b110, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[14] = '{3'b111, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};

    // Reset state, checked while reset is still held.
    #12;
    check_reset_values("reset");
    reset = 1'b1;
    tick();

    // Single load, response on the next cycle, result the cycle after.
    for (int i = 0; i < 15; i++) begin
      logic [4:0] rd;
      rd = 5'(i + 7);
      apply_stimulus(vecs[i].ltype, vecs[i].off, rd);
      check_output($sformatf("vec%0d count after issue", i), 32'(count), 32'd1);
      respond(vecs[i].word);
      check_result($sformatf("vec%0d", i), vecs[i].exp_data, rd, vecs[i].exp_mis);
      check_output($sformatf("vec%0d count after pop", i), 32'(count), 32'd0);
      tick();
      check_output($sformatf("vec%0d valid pulse", i), 32'(load_valid), 32'd0);
    end

    // Back-to-back issue and back-to-back responses stay in order.
    apply_stimulus(3'b101, 2'd2, 5'd1);
    apply_stimulus(3'b001, 2'd0, 5'd2);
    apply_stimulus(3'b010, 2'd0, 5'd3);
    check_output("b2b count", 32'(count), 32'd3);
    respond(32'hBEEF_8001);
    check_result("b2b r0", 32'h0000_BEEF, 5'd1, 1'b0);
    respond(32'hBEEF_8001);
    check_result("b2b r1", 32'hFFFF_8001, 5'd2, 1'b0);
    respond(32'hBEEF_8001);
    check_result("b2b r2", 32'hBEEF_8001, 5'd3, 1'b0);
    check_output("b2b count drained", 32'(count), 32'd0);

    // Full FIFO rejects a load even with a same-cycle pop.
    for (int i = 0; i < 4; i++) apply_stimulus(3'b010, 2'd0, 5'(10 + i));
    check_output("full issue_ready", 32'(issue_ready), 32'd0);
    check_output("full count", 32'(count), 32'd4);
    load = 1'b1; load_type = 3'b010; byte_offset = 2'd0; load_rd = 5'd20;
    memory_valid = 1'b1; memory_read_data = 32'h1111_1111;
    tick();
    memory_valid = 1'b0;
    check_output("full reject count", 32'(count), 32'd3);
    check_result("full pop0", 32'h1111_1111, 5'd10, 1'b0);
    tick();
    load = 1'b0;
    check_output("full retry count", 32'(count), 32'd4);
    respond(32'h2222_2222);
    check_result("full pop1", 32'h2222_2222, 5'd11, 1'b0);
    respond(32'h3333_3333);
    check_result("full pop2", 32'h3333_3333, 5'd12, 1'b0);
    respond(32'h4444_4444);
    check_result("full pop3", 32'h4444_4444, 5'd13, 1'b0);
    respond(32'h5555_5555);
    check_result("full pop retry", 32'h5555_5555, 5'd20, 1'b0);
    check_output("full drained", 32'(count), 32'd0);

    // Response with nothing outstanding: no result, sticky flag.
    check_output("unexp before", 32'(unexpected_response), 32'd0);
    respond(32'h9999_9999);
    check_output("unexp no valid", 32'(load_valid), 32'd0);
    check_output("unexp flag", 32'(unexpected_response), 32'd1);
    check_output("unexp count", 32'(count), 32'd0);
    repeat (3) tick();
    check_output("unexp sticky", 32'(unexpected_response), 32'd1);

    // Flush with a concurrent load and response discards everything.
    for (int i = 0; i < 3; i++) apply_stimulus(3'b000, 2'd0, 5'(i + 1));
    check_output("flush pre count", 32'(count), 32'd3);
    flush = 1'b1; load = 1'b1; load_rd = 5'd30; memory_valid = 1'b1;
    memory_read_data = 32'h7777_7777;
    tick();
    flush = 1'b0; load = 1'b0; memory_valid = 1'b0;
    check_output("flush count", 32'(count), 32'd0);
    check_output("flush no valid", 32'(load_valid), 32'd0);
    check_output("flush issue_ready", 32'(issue_ready), 32'd1);
    apply_stimulus(3'b100, 2'd0, 5'd3);
    respond(32'h0000_00AB);
    check_result("post flush", 32'h0000_00AB, 5'd3, 1'b0);

    // Asynchronous reset in the middle of activity.
    apply_stimulus(3'b010, 2'd1, 5'd9);
    apply_stimulus(3'b010, 2'd0, 5'd4);
    respond(32'hCAFE_0001);
    check_result("pre reset", 32'hCAFE_0001, 5'd9, 1'b1);
    check_output("pre reset count", 32'(count), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async reset");
    #1;
    reset = 1'b1;
    tick();

    // Push and response in the same cycle into an empty FIFO.
    load = 1'b1; load_type = 3'b010; byte_offset = 2'd0; load_rd = 5'd5;
    memory_valid = 1'b1; memory_read_data = 32'h1357_9BDF;
    tick();
    load = 1'b0; memory_valid = 1'b0;
    check_output("same-cycle count", 32'(count), 32'd1);
    check_output("same-cycle no valid", 32'(load_valid), 32'd0);
    check_output("same-cycle unexp", 32'(unexpected_response), 32'd1);
    respond(32'h2468_ACE0);
    check_result("same-cycle later", 32'h2468_ACE0, 5'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_receive_align.md
# memory_receive_align

Load-return stage directly downstream of the memory issue stage. It queues metadata for each issued load (size, sign, byte offset, destination register) in an in-order FIFO. When the data memory returns a word, it pops the oldest entry and extracts, sign- or zero-extends and registers the result for writeback. It also provides issue back-pressure, pipeline flush, and misalignment and unexpected-response reporting.

## Interface
- CORE, 0: core index, informational only
- DATA_WIDTH, 32: memory word and result width; fixed at 32 for byte/half extraction
- DEPTH, 4: outstanding-load FIFO entries; power of two, at least 2
- REG_SEL_BITS, 5: destination register index width

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- load  in  1  load issued this cycle, same cycle the issue stage asserts memory_read
- load_type  in  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- byte_offset  in  2  low two bits of the byte address; the issue stage drops these from memory_address
- load_rd  in  REG_SEL_BITS  destination register
- issue_ready  out  1  FIFO can accept a load this cycle
- memory_valid  in  1  memory read data valid this cycle, returned in issue order
- memory_read_data  in  DATA_WIDTH  returned word
- flush  in  1  discard all outstanding loads
- load_valid  out  1  registered result valid, one-cycle pulse per response
- load_data  out  DATA_WIDTH  extended result
- load_rd_out  out  REG_SEL_BITS  destination of load_data
- load_misaligned  out  1  qualifies load_data: the access was misaligned
- count  out  log2(DEPTH)+1  current FIFO occupancy
- unexpected_response  out  1  sticky: memory_valid arrived with an empty FIFO

## Operation
- Push: when load && issue_ready && !flush, write {load_type, byte_offset, load_rd} at the tail and increment tail mod DEPTH.
- Pop: when memory_valid && count!=0 && !flush, read the head entry, increment head mod DEPTH and register the result.
- If a push and a pop occur in the same cycle, count is unchanged.
- issue_ready = (count != DEPTH). There is no same-cycle bypass on full: when full, a load is rejected even if a pop occurs in that cycle.
- If load is asserted while issue_ready=0, the load is ignored. The issue stage must hold it.
- Byte extraction: byte = word[8*off+7 : 8*off].
  - LB sign-extends the byte; LBU zero-extends it.
- Halfword extraction: select word[31:16] if off[1]=1, else word[15:0].
  - LH sign-extends the halfword; LHU zero-extends it.
- LW returns the raw word and ignores the offset.
- load_misaligned = 1 in any of these cases:
  - LH/LHU with off[0]=1
  - LW with off!=0
  - any undefined load_type (011, 110, 111); these return the raw word.
- An empty-FIFO memory_valid produces no pop and no load_valid, and sets unexpected_response. That flag is cleared only by reset.
- Flush: the FIFO is emptied (head=tail=0, count=0) at the next edge and load_valid is 0 in the following cycle.
  - Flush overrides a push or pop in the same cycle; both are discarded.
  - Memory responses to flushed loads must not arrive after the flush. If one does, it is treated as unexpected.

## Timing
- Reset values: issue_ready=1, load_valid=0, load_data=0, load_rd_out=0, load_misaligned=0, count=0, unexpected_response=0.
- Latency: memory_valid at edge N produces load_valid, data, rd and misaligned all valid during cycle N+1. All outputs except issue_ready are registered.
- issue_ready is combinational from count only, with no path from load or memory_valid.
- Memory may return data no earlier than one cycle after the load is issued. A same-cycle push and response into an empty FIFO counts as unexpected.
- Responses may arrive back-to-back; the block sustains one result per cycle.
- If reset is asserted mid-operation, all queued loads are lost and load_valid drops immediately (asynchronously).

## Test plan
- Reset, then issue LB at off=3 (rd=7), then on the next cycle memory_valid with data 0x80FF_1234 -> load_valid=1 the cycle after, load_data=0xFFFF_FF80, rd_out=7, misaligned=0.
- Issue LHU at off=2, LH at off=0, and LW at off=0 back-to-back, then three consecutive responses of 0xBEEF_8001 -> results in order 0x0000_BEEF, 0xFFFF_8001, 0xBEEF_8001; count returns to 0.
- Issue 4 loads with no response -> issue_ready=0 and count=4; a fifth load plus a response in the same cycle -> the fifth is rejected and count=3; the fifth is accepted on retry.
- Issue LW at off=1 and LH at off=3 -> both return data with load_misaligned=1. LH at off=3 with word 0x1234_5678 yields 0x0000_1234.
- memory_valid with count=0 -> no load_valid and unexpected_response=1, which stays 1 until reset.
- 3 loads outstanding, then flush asserted together with a new load and a response -> next cycle count=0, no load_valid, issue_ready=1; assert reset with loads outstanding -> all outputs return to reset values without waiting for a clock.
